tick_irq_ctrl: RTL

TICK_IRQ_CTRL -- requirements
Module: tick_irq_ctrl

---
 rtl/tick_irq_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/tick_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tick_irq_ctrl
//  Description : Divides edges of a timer tick into level interrupts and
//                counts events lost while an interrupt is still pending.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_irq_ctrl #(
    parameter int DIV_W = 16,
    parameter int OVR_W = 8
) (
    input  logic             clk,
    input  logic             reset_p,
    input  logic             tick_in,
    input  logic             cfg_enable,
    input  logic [DIV_W-1:0] cfg_divider,
    input  logic             irq_ack,
    input  logic             ovr_clr,
    output logic             irq,
    output logic [OVR_W-1:0] overrun_cnt,
    output logic [31:0]      tick_total,
    output logic [1:0]       state_o
);

    localparam logic [1:0]       ST_IDLE   = 2'b00;
    localparam logic [1:0]       ST_RUN    = 2'b01;
    localparam logic [1:0]       ST_PEND   = 2'b10;
    localparam logic [DIV_W-1:0] c_DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic             r_irq;
    logic             r_tick_s;
    logic             r_tick_d;
    logic [DIV_W-1:0] r_div_cnt;
    logic [OVR_W-1:0] r_ovr_cnt;
    logic [31:0]      r_tick_total;

    logic             w_tick_acc;
    logic [DIV_W-1:0] w_eff_div;
    logic [DIV_W-1:0] w_eff_m1;
    logic             w_period_done;
    logic             w_ovr_max;

    // Edge detect runs on the registered copy of tick_in.
    assign w_tick_acc    = r_tick_s & ~r_tick_d;
    assign w_eff_div     = (cfg_divider == '0) ? c_DIV_ONE : cfg_divider;
    assign w_eff_m1      = w_eff_div - c_DIV_ONE;
    // ">=" lets a shrunk divider complete the period on the next tick.
    assign w_period_done = w_tick_acc && (r_div_cnt >= w_eff_m1);
    assign w_ovr_max     = (r_ovr_cnt == '1);

    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_state      <= ST_IDLE;
            r_irq        <= 1'b0;
            r_tick_s     <= 1'b0;
            r_tick_d     <= 1'b0;
            r_div_cnt    <= '0;
            r_ovr_cnt    <= '0;
            r_tick_total <= '0;
        end else begin
            r_tick_s <= tick_in;
            r_tick_d <= r_tick_s;

            if (cfg_enable && w_tick_acc) begin
                r_tick_total <= r_tick_total + 32'd1;
            end

            if (!cfg_enable) begin
                r_state   <= ST_IDLE;
                r_irq     <= 1'b0;
                r_div_cnt <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state   <= ST_RUN;
                        r_irq     <= 1'b0;
                        r_div_cnt <= '0;
                    end
                    ST_RUN: begin
                        if (w_tick_acc) begin
                            r_div_cnt <= w_period_done ? '0 : r_div_cnt + c_DIV_ONE;
                        end
                        if (w_period_done) begin
                            r_state <= ST_PEND;
                            r_irq   <= 1'b1;
                        end
                    end
                    ST_PEND: begin
                        if (w_tick_acc) begin
                            r_div_cnt <= w_period_done ? '0 : r_div_cnt + c_DIV_ONE;
                        end
                        if (w_period_done) begin
                            r_irq <= 1'b1;
                            if (!irq_ack && !w_ovr_max) begin
                                r_ovr_cnt <= r_ovr_cnt + 1'b1;
                            end
                        end else if (irq_ack) begin
                            r_state <= ST_RUN;
                            r_irq   <= 1'b0;
                        end
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_irq     <= 1'b0;
                        r_div_cnt <= '0;
                    end
                endcase
            end

            // Clear is written last so it wins over a same-cycle increment.
            if (ovr_clr) begin
                r_ovr_cnt <= '0;
            end
        end
    end

    assign irq         = r_irq;
    assign overrun_cnt = r_ovr_cnt;
    assign tick_total  = r_tick_total;
    assign state_o     = r_state;

endmodule
`default_nettype wire
